// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
// slave is the controller's view; master is the pipeline/bench view.
interface pipe_hazard_ctrl_if;
  logic [6:0]  id_op_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  ex_rd_i;
  logic        ex_regwrite_i;
  logic        ex_memread_i;
  logic        br_taken_i;
  logic        mem_req_i;
  logic        mem_ready_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        pipe_en_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  modport slave (
    input  id_op_i, id_rs1_i, id_rs2_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
    input  br_taken_i, mem_req_i, mem_ready_i,
    output pc_write_o, ifid_write_o, pipe_en_o, ifid_flush_o, idex_bubble_o,
    output stall_cnt_o, flush_cnt_o
  );

  modport master (
    output id_op_i, id_rs1_i, id_rs2_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
    output br_taken_i, mem_req_i, mem_ready_i,
    input  pc_write_o, ifid_write_o, pipe_en_o, ifid_flush_o, idex_bubble_o,
    input  stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/freeze controller
// Mealy outputs from RUN/BRWAIT/MEMWAIT plus current hazard inputs; saturating perf counters.
module pipe_hazard_ctrl (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam logic [6:0] OP_NONE = 7'b0000000;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_SW   = 7'b0100011;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BRWAIT  = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        br_pend_q, br_pend_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  logic uses_rs1, uses_rs2, dep, load_use, br_dep, mem_hold;
  logic pc_write, ifid_write, pipe_en, ifid_flush, idex_bubble;

  always_comb begin
    uses_rs1 = (hz.id_op_i != OP_NONE);
    uses_rs2 = (hz.id_op_i == OP_RTYP) || (hz.id_op_i == OP_BEQ) || (hz.id_op_i == OP_SW);
    dep      = (hz.ex_rd_i != 5'd0) &&
               ((uses_rs1 && (hz.ex_rd_i == hz.id_rs1_i)) ||
                (uses_rs2 && (hz.ex_rd_i == hz.id_rs2_i)));
    load_use = hz.ex_memread_i && dep;
    br_dep   = (hz.id_op_i == OP_BEQ) && hz.ex_regwrite_i && dep;
    mem_hold = hz.mem_req_i && !hz.mem_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
    end
  end

  // A freeze taken from BRWAIT remembers the owed stall cycle and replays it after MEMWAIT.
  always_comb begin
    state_d   = state_q;
    br_pend_d = br_pend_q;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d   = MEMWAIT;
          br_pend_d = 1'b0;
        end else if (br_dep && hz.ex_memread_i) begin
          state_d = BRWAIT;
        end
      end
      BRWAIT: begin
        if (mem_hold) begin
          state_d   = MEMWAIT;
          br_pend_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (hz.mem_ready_i) begin
          state_d   = br_pend_q ? BRWAIT : RUN;
          br_pend_d = 1'b0;
        end
      end
      default: begin
        state_d   = RUN;
        br_pend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    pipe_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst_i) begin
      case (state_q)
        RUN: begin
          if (mem_hold) begin
            pipe_en = 1'b0;
          end else if (load_use || br_dep) begin
            pipe_en     = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            pipe_en    = 1'b1;
            ifid_flush = hz.br_taken_i;
          end
        end
        BRWAIT: begin
          if (!mem_hold) begin
            pipe_en     = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MEMWAIT: begin
          if (hz.mem_ready_i) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            pipe_en    = 1'b1;
          end
        end
        default: begin
          pipe_en = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_write && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_flush && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.pc_write_o    = pc_write;
  assign hz.ifid_write_o  = ifid_write;
  assign hz.pipe_en_o     = pipe_en;
  assign hz.ifid_flush_o  = ifid_flush;
  assign hz.idex_bubble_o = idex_bubble;
  assign hz.stall_cnt_o   = stall_cnt_q;
  assign hz.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - bench for pipe_hazard_ctrl
// Directed vector table, saturation/async-reset sequences, random run against an owed-cycle model.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] NO  = 7'b0000000;
  // expected {pc_write, ifid_write, pipe_en, ifid_flush, idex_bubble}
  localparam logic [4:0] E_RUN = 5'b11100;
  localparam logic [4:0] E_STL = 5'b00101;
  localparam logic [4:0] E_FRZ = 5'b00000;
  localparam logic [4:0] E_FLS = 5'b11110;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, bt, mreq, mrdy;
    logic [4:0]  exp;
    logic [15:0] es, ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;

  pipe_hazard_ctrl_if hz ();
  pipe_hazard_ctrl dut (.clk_i(clk), .rst_i(rst_n), .hz(hz));

  always #5 clk = ~clk;

  int m_owed;
  bit m_frozen;
  int m_stall, m_flush;

  function automatic vec_t mk(logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic rw, logic mr, logic bt, logic mreq, logic mrdy,
                              logic [4:0] exp, logic [15:0] es, logic [15:0] ef);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.mr = mr;
    v.bt = bt; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp; v.es = es; v.ef = ef;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    hz.id_op_i = v.op; hz.id_rs1_i = v.rs1; hz.id_rs2_i = v.rs2; hz.ex_rd_i = v.rd;
    hz.ex_regwrite_i = v.rw; hz.ex_memread_i = v.mr; hz.br_taken_i = v.bt;
    hz.mem_req_i = v.mreq; hz.mem_ready_i = v.mrdy;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {hz.pc_write_o, hz.ifid_write_o, hz.pipe_en_o, hz.ifid_flush_o, hz.idex_bubble_o};
  endfunction

  // Model: a load-fed beq owes one extra stall cycle; a freeze preserves whatever is owed.
  task automatic model_step(input vec_t v, output logic [4:0] e);
    bit u1, u2, dep, lu, bd, hold;
    u1   = (v.op != NO);
    u2   = (v.op == R) || (v.op == BEQ) || (v.op == SW);
    dep  = (v.rd != 0) && ((u1 && v.rd == v.rs1) || (u2 && v.rd == v.rs2));
    lu   = v.mr && dep;
    bd   = (v.op == BEQ) && v.rw && dep;
    hold = v.mreq && !v.mrdy;
    if (m_frozen) begin
      e = v.mrdy ? E_RUN : E_FRZ;
      if (v.mrdy) m_frozen = 0;
    end else if (m_owed > 0) begin
      if (hold) begin e = E_FRZ; m_frozen = 1; end
      else begin e = E_STL; m_owed--; end
    end else if (hold) begin
      e = E_FRZ; m_frozen = 1;
    end else if (lu || bd) begin
      e = E_STL;
      if (bd && v.mr) m_owed = 1;
    end else begin
      e = v.bt ? E_FLS : E_RUN;
    end
    if (!e[4]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
    if (e[1])  m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
  endtask

  task automatic do_reset();
    vec_t n;
    n = mk(R, 1, 2, 0, 0, 0, 0, 0, 1, E_RUN, 0, 0);
    drive(n);
    rst_n = 1'b0;
    #1;
    chk("rst_outs", outs(), E_FRZ);
    chk("rst_stall_cnt", hz.stall_cnt_o, 0);
    chk("rst_flush_cnt", hz.flush_cnt_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_owed = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(R,   5, 1, 5, 1, 1, 0, 0, 1, E_STL, 0, 0));
    tbl.push_back(mk(R,   5, 1, 6, 1, 0, 0, 0, 1, E_RUN, 1, 0));
    tbl.push_back(mk(BEQ, 5, 0, 5, 1, 1, 0, 0, 1, E_STL, 1, 0));
    tbl.push_back(mk(R,   1, 2, 0, 0, 0, 0, 0, 1, E_STL, 2, 0));
    tbl.push_back(mk(BEQ, 5, 0, 0, 0, 0, 1, 0, 1, E_FLS, 3, 0));
    tbl.push_back(mk(NO,  0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 3, 1));
    tbl.push_back(mk(R,   0, 3, 0, 1, 1, 0, 0, 1, E_RUN, 3, 1));
    tbl.push_back(mk(R,   5, 1, 5, 1, 1, 0, 1, 0, E_FRZ, 3, 1));
    tbl.push_back(mk(R,   5, 1, 5, 1, 1, 0, 1, 0, E_FRZ, 4, 1));
    tbl.push_back(mk(R,   5, 1, 5, 1, 1, 0, 1, 0, E_FRZ, 5, 1));
    tbl.push_back(mk(R,   5, 1, 5, 1, 1, 0, 1, 1, E_RUN, 6, 1));
    tbl.push_back(mk(R,   5, 1, 5, 1, 1, 0, 0, 1, E_STL, 6, 1));
    tbl.push_back(mk(BEQ, 3, 4, 3, 1, 0, 1, 0, 1, E_STL, 7, 1));
    tbl.push_back(mk(BEQ, 7, 0, 7, 1, 1, 0, 0, 1, E_STL, 8, 1));
    tbl.push_back(mk(R,   1, 2, 0, 0, 0, 0, 1, 0, E_FRZ, 9, 1));
    tbl.push_back(mk(R,   1, 2, 0, 0, 0, 0, 1, 1, E_RUN, 10, 1));
    tbl.push_back(mk(R,   1, 2, 0, 0, 0, 0, 0, 1, E_STL, 10, 1));
    tbl.push_back(mk(R,   1, 2, 0, 0, 0, 0, 0, 1, E_RUN, 11, 1));
    tbl.push_back(mk(NO,  5, 5, 5, 1, 1, 0, 0, 1, E_RUN, 11, 1));
    tbl.push_back(mk(LW,  1, 5, 5, 1, 1, 0, 0, 1, E_RUN, 11, 1));
    tbl.push_back(mk(SW,  1, 9, 9, 1, 1, 0, 0, 1, E_STL, 11, 1));
    tbl.push_back(mk(R,   1, 2, 0, 0, 0, 0, 0, 1, E_RUN, 12, 1));
    tbl.push_back(mk(BEQ, 1, 2, 0, 0, 0, 1, 0, 1, E_FLS, 12, 1));
    tbl.push_back(mk(R,   1, 2, 0, 0, 0, 0, 0, 1, E_RUN, 12, 2));

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), outs(), tbl[i].exp);
      chk($sformatf("vec%0d_stall", i), hz.stall_cnt_o, tbl[i].es);
      chk($sformatf("vec%0d_flush", i), hz.flush_cnt_o, tbl[i].ef);
    end

    // Saturation: 65534 freeze cycles, then three load-use stalls.
    do_reset();
    drive(mk(R, 1, 2, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0));
    repeat (65534) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat_preload", hz.stall_cnt_o, 16'hFFFE);
    drive(mk(R, 1, 2, 0, 0, 0, 0, 1, 1, E_RUN, 0, 0));
    @(negedge clk);
    drive(mk(R, 5, 1, 5, 1, 1, 0, 0, 1, E_STL, 0, 0));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sat_stall_outs", outs(), E_STL);
      @(negedge clk);
      #1;
      chk("sat_hold", hz.stall_cnt_o, 16'hFFFF);
    end

    // Async reset in the middle of MEMWAIT.
    do_reset();
    drive(mk(R, 1, 2, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0));
    repeat (4) @(posedge clk);
    #1;
    chk("pre_arst_cnt", hz.stall_cnt_o, 4);
    chk("pre_arst_outs", outs(), E_FRZ);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", outs(), E_FRZ);
    chk("arst_stall_cnt", hz.stall_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(R, 1, 2, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0));
    #1;
    chk("post_arst_run", outs(), E_RUN);
    @(negedge clk);
    #1;
    chk("post_arst_run2", outs(), E_RUN);
    chk("post_arst_cnt", hz.stall_cnt_o, 0);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      logic [4:0] e;
      logic [15:0] es, ef;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: v.op = R;
        1: v.op = BEQ;
        2: v.op = SW;
        3: v.op = LW;
        4: v.op = NO;
        default: v.op = 7'($urandom);
      endcase
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.rw  = 1'($urandom);
      v.mr  = 1'($urandom);
      v.bt  = 1'($urandom);
      v.mreq = ($urandom_range(0, 9) < 3);
      v.mrdy = 1'($urandom);
      @(negedge clk);
      drive(v);
      es = 16'(m_stall);
      ef = 16'(m_flush);
      model_step(v, e);
      #1;
      chk("rand_outs", outs(), e);
      chk("rand_stall", hz.stall_cnt_o, es);
      chk("rand_flush", hz.flush_cnt_o, ef);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port id_op_i, input, 7, opcode of instruction in ID.
REQ-004 SHALL have ports id_rs1_i and id_rs2_i, input, 5 each, source registers in ID.
REQ-005 SHALL have ports ex_rd_i (input, 5), ex_regwrite_i (input, 1) and ex_memread_i (input, 1), destination and controls of instruction in EX.
REQ-006 SHALL have port br_taken_i, input, 1, beq in ID compares equal (ID-resolved branch).
REQ-007 SHALL have ports mem_req_i (input, 1), MEM stage has lw or sw, and mem_ready_i (input, 1), data memory completes access this cycle.
REQ-008 SHALL have outputs pc_write_o, ifid_write_o, pipe_en_o (EX/MEM, MEM/WB enable), ifid_flush_o and idex_bubble_o, 1 bit each.
REQ-009 SHALL have outputs stall_cnt_o and flush_cnt_o, 16 bit each, saturating performance counters.

Function
REQ-010 SHALL implement FSM states RUN, BRWAIT, MEMWAIT; outputs are Mealy (state plus current inputs, same cycle).
REQ-011 SHALL decode uses_rs2 = 1 for opcodes 0110011 (R-type), 1100011 (beq) and 0100011 (sw), else 0; uses_rs1 = 1 for all opcodes except 0000000.
REQ-012 SHALL define dep = (ex_rd_i != 0) AND ((uses_rs1 AND ex_rd_i == id_rs1_i) OR (uses_rs2 AND ex_rd_i == id_rs2_i)).
REQ-013 SHALL define load_use = ex_memread_i AND dep, and br_dep = (id_op_i == 1100011) AND ex_regwrite_i AND dep.
REQ-014 SHALL treat a cycle as "stall" when, in RUN, load_use OR br_dep holds, or when in BRWAIT.
- Stall outputs: pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1, pipe_en_o = 1.
REQ-015 SHALL go RUN->BRWAIT when br_dep AND ex_memread_i (load feeding beq, 2 stall cycles); BRWAIT SHALL return to RUN after exactly 1 cycle.
REQ-016 SHALL, in RUN with mem_req_i = 1 and mem_ready_i = 0, freeze the pipe: pc_write_o = ifid_write_o = pipe_en_o = 0, idex_bubble_o = 0, ifid_flush_o = 0, and go to MEMWAIT.
REQ-017 SHALL hold the MEMWAIT freeze outputs until a cycle with mem_ready_i = 1; in that cycle outputs are as in RUN with no hazard, and next state is RUN.
REQ-018 SHALL give freeze priority over stall, and stall priority over flush; a pending BRWAIT entered before a freeze resumes (BRWAIT count not consumed) after MEMWAIT exits.
REQ-019 SHALL assert ifid_flush_o = 1 for exactly the cycle where state is RUN, br_taken_i = 1, no stall and no freeze; pc_write_o = ifid_write_o = 1 in that cycle.
REQ-020 SHALL in a RUN cycle without hazard, freeze or flush drive pc_write_o = ifid_write_o = pipe_en_o = 1, ifid_flush_o = idex_bubble_o = 0.
REQ-021 SHALL increment stall_cnt_o each cycle pc_write_o = 0 (stall or freeze), and flush_cnt_o each cycle ifid_flush_o = 1; both saturate at 16'hFFFF and never wrap.

Reset
REQ-022 SHALL, while rst_i = 0, force state RUN, stall_cnt_o = flush_cnt_o = 0, pc_write_o = ifid_write_o = pipe_en_o = 0, ifid_flush_o = idex_bubble_o = 0, regardless of the clock.
REQ-023 SHALL abandon any BRWAIT or MEMWAIT on reset assertion mid-operation; the first cycle after release is RUN.

Verification
REQ-024 SHALL pass: lw x5 in EX (ex_memread_i = 1, ex_rd_i = 5), ID add x6,x5,x1 -> one cycle pc_write_o = 0, idex_bubble_o = 1; stall_cnt_o 0->1.
REQ-025 SHALL pass: lw x5 in EX, ID beq x5,x0 -> two consecutive stall cycles (RUN, BRWAIT); then with br_taken_i = 1 -> ifid_flush_o = 1 for one cycle; flush_cnt_o = 1.
REQ-026 SHALL pass: ex_rd_i = 0 with ex_memread_i = 1 and id_rs1_i = 0 -> no stall.
REQ-027 SHALL pass: mem_req_i = 1, mem_ready_i low 3 cycles then high -> pipe_en_o = 0 for 3 cycles, 1 on 4th; stall_cnt_o += 3; simultaneous load_use during the freeze produces no bubble until exit.
REQ-028 SHALL pass: preload stall_cnt_o to 16'hFFFE, stall 3 cycles -> holds at 16'hFFFF.
REQ-029 SHALL pass: rst_i low asynchronously mid-MEMWAIT -> outputs and counters zero immediately; after release, state RUN with pc_write_o = 1.
